// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  core_pkg
//  Shared types and constants for the memory-port arbiter.
//  Revision: 1.0
// ============================================================================
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_EXEC  = 1'b1;

  localparam logic MEM_OP_RD = 1'b0;
  localparam logic MEM_OP_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
//  arb_starve_counter
//  Saturating up/clear counter tracking exec wins over a waiting fetch.
//  Revision: 1.0
// ============================================================================
module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  mem_port_arbiter
//  Shares one fixed-latency memory port between fetch and exec requesters.
//  Revision: 1.0
// ============================================================================
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              fetch_kill_i,
  output logic              fetch_fin_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic              exec_req_i,
  input  logic              exec_we_i,
  input  logic [ADDR_W-1:0] exec_addr_i,
  input  logic [DATA_W-1:0] exec_wdata_i,
  input  logic [3:0]        exec_wmask_i,
  output logic              exec_fin_o,
  output logic [DATA_W-1:0] exec_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-3:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [LAT_W-1:0]  lat_q;

  logic w_starve_sat;
  logic w_exec_wins;
  logic w_fetch_wins;
  logic w_idle;
  logic w_fetch_done;
  logic w_exec_done;
  logic w_unused_addr_bits;

  assign w_unused_addr_bits = ^{fetch_addr_i[1:0], exec_addr_i[1:0]};

  // Exec also wins when saturated but fetch has gone away, so a lone exec never stalls.
  assign w_idle       = (state_q == ARB_IDLE);
  assign w_exec_wins  = exec_req_i && (!w_starve_sat || !fetch_req_i);
  assign w_fetch_wins = fetch_req_i && !w_exec_wins;

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (w_idle && w_exec_wins && fetch_req_i),
    .clr_i (w_idle && w_fetch_wins),
    .sat_o (w_starve_sat)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    kill_d  = kill_q;
    if ((state_q != ARB_IDLE) && (grant_q == GNT_FETCH) && fetch_kill_i) begin
      kill_d = 1'b1;
    end
    case (state_q)
      ARB_IDLE: begin
        if (w_exec_wins || w_fetch_wins) begin
          state_d = ARB_ISSUE;
          grant_d = w_exec_wins ? GNT_EXEC : GNT_FETCH;
          kill_d  = w_fetch_wins && fetch_kill_i;
        end
      end
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (lat_q == '0) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= GNT_FETCH;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      we_q    <= MEM_OP_RD;
      wdata_q <= '0;
      wmask_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      kill_q  <= kill_d;
      if (w_idle && (w_exec_wins || w_fetch_wins)) begin
        addr_q  <= w_exec_wins ? exec_addr_i[ADDR_W-1:2] : fetch_addr_i[ADDR_W-1:2];
        we_q    <= w_exec_wins ? exec_we_i : MEM_OP_RD;
        wdata_q <= w_exec_wins ? exec_wdata_i : '0;
        wmask_q <= w_exec_wins ? exec_wmask_i : 4'h0;
      end
      if (state_q == ARB_ISSUE) begin
        lat_q <= LAT_W'(MEM_LAT - 1);
      end else if ((state_q == ARB_WAIT) && (lat_q != '0)) begin
        lat_q <= lat_q - 1'b1;
      end
    end
  end

  assign mem_en_o    = (state_q == ARB_ISSUE);
  assign mem_we_o    = mem_en_o && (we_q == MEM_OP_WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

  // A kill arriving in DONE itself also suppresses the pulse.
  assign w_fetch_done  = (state_q == ARB_DONE) && (grant_q == GNT_FETCH);
  assign w_exec_done   = (state_q == ARB_DONE) && (grant_q == GNT_EXEC);
  assign fetch_fin_o   = w_fetch_done && !kill_q && !fetch_kill_i;
  assign fetch_rdata_o = w_fetch_done ? mem_rdata_i : '0;
  assign exec_fin_o    = w_exec_done;
  assign exec_rdata_o  = w_exec_done ? mem_rdata_i : '0;

endmodule
`default_nettype wire
